// File: rtl/minterm_sweeper.sv
// Serial-loaded 2^N-bit truth table, swept in ascending input order as a valid/ready stream of (vec, s) beats.
// Latency: first beat the cycle after start; done pulses one cycle after the last accepted beat.
// Backpressure: out_ready=0 holds vec, s and ones stable; beats are never dropped or repeated.
module minterm_sweeper #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         load_bit,
  input  logic         start,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] vec,
  output logic         s,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones,
  output logic         all_one,
  output logic         all_zero
);

  localparam int D = 1 << N;
  localparam logic [N-1:0] LAST = N'(D - 1);
  localparam logic [N:0]   FULL = (N + 1)'(D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [D-1:0]   tt;
  logic [N-1:0]   cnt;
  logic [N:0]     ones_r;
  logic [N:0]     ones_inc;
  logic           all_one_r;
  logic           all_zero_r;
  logic           last_beat;

  assign last_beat = (cnt == LAST);
  assign ones_inc  = ones_r + {{N{1'b0}}, tt[cnt]};

  // State register plus the datapath registers it governs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tt         <= '0;
      cnt        <= '0;
      ones_r     <= '0;
      all_one_r  <= 1'b0;
      all_zero_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            cnt        <= '0;
            ones_r     <= '0;
            all_one_r  <= 1'b0;
            all_zero_r <= 1'b0;
          end else if (load) begin
            tt <= {tt[D-2:0], load_bit};
          end
        end
        SWEEP: begin
          if (out_ready) begin
            ones_r <= ones_inc;
            if (last_beat) begin
              // Flags come from the final count so they are already valid alongside done.
              all_one_r  <= (ones_inc == FULL);
              all_zero_r <= (ones_inc == '0);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (out_ready && last_beat) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    vec       = '0;
    s         = 1'b0;
    case (state)
      SWEEP: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        vec       = cnt;
        s         = tt[cnt];
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign ones     = ones_r;
  assign all_one  = all_one_r;
  assign all_zero = all_zero_r;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Bench for minterm_sweeper: directed scenarios plus random tables/back-pressure against an integer table model.
module tb_minterm_sweeper;

  logic       clk = 1'b0;
  logic       reset, load, load_bit, start, out_ready;
  logic       out_valid, s, busy, done, all_one, all_zero;
  logic [3:0] vec;
  logic [4:0] ones;

  logic       load2, load_bit2, start2, ready2;
  logic       out_valid2, s2, busy2, done2, all_one2, all_zero2;
  logic [1:0] vec2;
  logic [2:0] ones2;

  int         checks = 0;
  int         errors = 0;
  logic [15:0] tt_m;

  always #5 clk = ~clk;

  minterm_sweeper #(.N(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_bit(load_bit), .start(start),
    .out_ready(out_ready), .out_valid(out_valid), .vec(vec), .s(s), .busy(busy),
    .done(done), .ones(ones), .all_one(all_one), .all_zero(all_zero)
  );

  minterm_sweeper #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .load_bit(load_bit2), .start(start2),
    .out_ready(ready2), .out_valid(out_valid2), .vec(vec2), .s(s2), .busy(busy2),
    .done(done2), .ones(ones2), .all_one(all_one2), .all_zero(all_zero2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: the table is an integer that each loaded bit shifts into from the bottom.
  task automatic load_table(input logic [15:0] val);
    for (int i = 15; i >= 0; i--) begin
      load     = 1'b1;
      load_bit = val[i];
      @(negedge clk);
      tt_m = {tt_m[14:0], val[i]};
    end
    load = 1'b0;
  endtask

  // mode 0: ready always, 1: ready alternating starting high, 2: random ready.
  // junk: random start/load pulses during the sweep. exp_lat < 0 skips the latency check.
  task automatic sweep(input int mode, input bit junk, input int exp_lat);
    int         beats = 0;
    int         cyc = 0;
    int         ones_m = 0;
    bit         prev_stall = 1'b0;
    bit         r;
    logic [3:0] hold_vec = '0;
    logic [4:0] hold_ones = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
    cyc   = 1;
    chk("busy_on_start", 32'(busy), 1);
    while (beats < 16 && cyc < 200) begin
      chk("valid", 32'(out_valid), 1);
      chk("vec", 32'(vec), 32'(beats));
      chk("s", 32'(s), 32'(tt_m[beats]));
      chk("ones_running", 32'(ones), 32'(ones_m));
      if (prev_stall) begin
        chk("stall_vec", 32'(vec), 32'(hold_vec));
        chk("stall_ones", 32'(ones), 32'(hold_ones));
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (junk) begin
        start    = 1'($urandom_range(0, 1));
        load     = 1'($urandom_range(0, 1));
        load_bit = 1'($urandom_range(0, 1));
      end
      if (r) begin
        ones_m += int'(tt_m[beats]);
        beats++;
      end
      prev_stall = !r;
      hold_vec   = vec;
      hold_ones  = ones;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    load  = 1'b0;
    chk("beat_count", 32'(beats), 16);
    chk("done_pulse", 32'(done), 1);
    chk("valid_in_done", 32'(out_valid), 0);
    chk("busy_in_done", 32'(busy), 0);
    if (exp_lat >= 0) chk("done_latency", 32'(cyc), 32'(exp_lat));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("ones_final", 32'(ones), 32'($countones(tt_m)));
    chk("ones_vs_beats", 32'(ones), 32'(ones_m));
    chk("all_one", 32'(all_one), 32'(tt_m == 16'hFFFF));
    chk("all_zero", 32'(all_zero), 32'(tt_m == 16'h0000));
  endtask

  initial begin
    logic [3:0] val2;
    reset = 1'b1; load = 1'b0; load_bit = 1'b0; start = 1'b0; out_ready = 1'b1;
    load2 = 1'b0; load_bit2 = 1'b0; start2 = 1'b0; ready2 = 1'b1;
    tt_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_ones", 32'(ones), 0);
    chk("rst_flags", 32'({all_one, all_zero}), 0);
    reset = 1'b0;

    sweep(0, 1'b0, 17);                       // unloaded table
    load_table(16'hFFFF);  sweep(0, 1'b0, 17); // tautology
    load_table(16'h8001);  sweep(0, 1'b0, 17); // sparse
    load_table(16'hA5A5);  sweep(1, 1'b0, 32); // back-pressure

    // start+load collision: the load bit must be dropped
    load = 1'b1; load_bit = ~tt_m[0];
    sweep(0, 1'b0, 17);

    // start/load noise mid-sweep on a random table
    load_table(16'($urandom));
    sweep(2, 1'b1, -1);

    for (int k = 0; k < 3; k++) begin
      load_table(16'($urandom));
      sweep(2, 1'b0, -1);
    end

    // reset after 5 accepted beats
    load_table(16'hFFFF);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_vec", 32'(vec), 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ones", 32'(ones), 0);
    chk("mid_rst_vec", 32'(vec), 0);
    tt_m = '0;
    sweep(0, 1'b0, 17);

    // N=2 instance, table 0b0110
    val2 = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      load2 = 1'b1;
      load_bit2 = val2[i];
      @(negedge clk);
    end
    load2  = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      chk("n2_valid", 32'(out_valid2), 1);
      chk("n2_vec", 32'(vec2), 32'(v));
      chk("n2_s", 32'(s2), 32'(val2[v]));
      @(negedge clk);
    end
    chk("n2_done", 32'(done2), 1);
    chk("n2_ones", 32'(ones2), 2);
    chk("n2_flags", 32'({all_one2, all_zero2}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
